// File: rtl/megarom_bank_controller.sv
`default_nettype none
// ============================================================================
//  Module   : megarom_bank_controller
//  Purpose  : Device-side megarom engine. It snoops slot writes to keep four
//             bank registers up to date. It translates cartridge accesses in
//             4000h-BFFFh into byte requests on a req/ack memory port. It
//             holds the Z80 with WAIT_n until the memory side completes.
//  Ports    : CLK, RESET_n        - clock, async active-low reset
//             BUS_RESET_n         - MSX bus reset (sync, active-low)
//             SLTSL_n/MERQ_n/RD_n/WR_n, ADDR, DIN - MSX bus inputs
//             DOUT, BUSDIR_n, WAIT_n              - MSX bus outputs
//             BANK_REG_*, WRITE_PROTECT, IS_16K_BANK, CS1_MASK, CS2_MASK,
//             MEM_TOP_ADDR        - configuration (quasi-static)
//             MEM_REQ/WE/ADDR/WDATA, MEM_ACK/RDATA - memory handshake
//  Revision : 1.0 - initial release
// ============================================================================
module megarom_bank_controller #(
  parameter int MEM_AW = 32
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  input  logic                   BUS_RESET_n,
  input  logic                   SLTSL_n,
  input  logic                   MERQ_n,
  input  logic                   RD_n,
  input  logic                   WR_n,
  input  logic [15:0]            ADDR,
  input  logic [7:0]             DIN,
  output logic [7:0]             DOUT,
  output logic                   BUSDIR_n,
  output logic                   WAIT_n,
  input  logic [3:0][15:0]       BANK_REG_ADDR,
  input  logic [15:0]            BANK_REG_ADDR_MASK,
  input  logic [7:0]             BANK_REG_MASK,
  input  logic [3:0][7:0]        BANK_REG_INIT,
  input  logic                   WRITE_PROTECT,
  input  logic                   IS_16K_BANK,
  input  logic                   CS1_MASK,
  input  logic                   CS2_MASK,
  input  logic [MEM_AW-1:0]      MEM_TOP_ADDR,
  output logic                   MEM_REQ,
  output logic                   MEM_WE,
  output logic [MEM_AW-1:0]      MEM_ADDR,
  output logic [7:0]             MEM_WDATA,
  input  logic                   MEM_ACK,
  input  logic [7:0]             MEM_RDATA
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [3:0][7:0]       bank_q,      bank_d;
  logic                  rd_n_q,      rd_n_d;
  logic                  wr_n_q,      wr_n_d;
  logic                  is_read_q,   is_read_d;
  logic                  abort_q,     abort_d;
  logic                  discard_q,   discard_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic [MEM_AW-1:0]     mem_addr_q,  mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic [7:0]            dout_q,      dout_d;
  logic                  busdir_n_q,  busdir_n_d;
  logic                  wait_n_q,    wait_n_d;

  logic                  w_rd_n;
  logic                  w_wr_n;
  logic                  w_rd_fall;
  logic                  w_wr_fall;
  logic                  w_in_window;
  logic [3:0]            w_match;
  logic                  w_bank_hit;
  logic [1:0]            w_bank_sel;
  logic [7:0]            w_bank_val;
  logic [21:0]           w_offset;
  logic [MEM_AW-1:0]     w_mem_addr;
  logic                  w_start_rd;
  logic                  w_start_wr;

  // Combined strobes: an access exists only while the slot is selected on a
  // memory cycle.
  assign w_rd_n    = SLTSL_n | MERQ_n | RD_n;
  assign w_wr_n    = SLTSL_n | MERQ_n | WR_n;
  assign w_rd_fall = rd_n_q & ~w_rd_n;
  assign w_wr_fall = wr_n_q & ~w_wr_n;

  assign w_in_window = ((ADDR[15:14] == 2'b01) & ~CS1_MASK) |
                       ((ADDR[15:14] == 2'b10) & ~CS2_MASK);

  // A masked bit of BANK_REG_ADDR_MASK removes that address bit from the match.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_match
      assign w_match[gi] = ((ADDR ^ BANK_REG_ADDR[gi]) & ~BANK_REG_ADDR_MASK) == 16'h0000;
    end
  endgenerate

  assign w_bank_hit = |w_match;

  // 8K pages start at 4000h, so page index = ADDR[14:13] - 2 (mod 4).
  assign w_bank_sel = IS_16K_BANK ? {1'b0, ADDR[15]} : (ADDR[14:13] + 2'd2);
  assign w_bank_val = bank_q[w_bank_sel];
  assign w_offset   = IS_16K_BANK ? {w_bank_val, ADDR[13:0]}
                                  : {1'b0, w_bank_val, ADDR[12:0]};
  assign w_mem_addr = MEM_TOP_ADDR + MEM_AW'(w_offset);

  // Writes that land on a bank register are consumed by the mapper and are
  // never forwarded to memory.
  assign w_start_rd = w_rd_fall & w_in_window;
  assign w_start_wr = w_wr_fall & w_in_window & ~WRITE_PROTECT & ~w_bank_hit;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    rd_n_d      = w_rd_n;
    wr_n_d      = w_wr_n;
    is_read_d   = is_read_q;
    abort_d     = abort_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dout_d      = dout_q;
    busdir_n_d  = busdir_n_q;
    wait_n_d    = wait_n_q;

    if (!BUS_RESET_n) begin
      bank_d = BANK_REG_INIT;
    end else if (w_wr_fall) begin
      for (int i = 0; i < 4; i++) begin
        if (w_match[i]) begin
          bank_d[i] = DIN & BANK_REG_MASK;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (BUS_RESET_n && (w_start_rd || w_start_wr)) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          wait_n_d    = 1'b0;
          mem_we_d    = ~w_start_rd;
          mem_addr_d  = w_mem_addr;
          mem_wdata_d = DIN;
          is_read_d   = w_start_rd;
          abort_d     = 1'b0;
          discard_d   = 1'b0;
        end
      end

      ST_REQ: begin
        // The memory transaction cannot be cancelled; remember why its
        // result must not reach the bus.
        if (is_read_q && w_rd_n) begin
          abort_d = 1'b1;
        end
        if (!BUS_RESET_n) begin
          discard_d = 1'b1;
        end
        if (MEM_ACK) begin
          mem_req_d = 1'b0;
          wait_n_d  = 1'b1;
          if (discard_q || !BUS_RESET_n) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            if (is_read_q && !abort_q && !w_rd_n) begin
              dout_d     = MEM_RDATA;
              busdir_n_d = 1'b0;
            end
          end
        end
      end

      ST_HOLD: begin
        if (is_read_q ? w_rd_n : w_wr_n) begin
          state_d    = ST_IDLE;
          dout_d     = 8'h00;
          busdir_n_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!BUS_RESET_n) begin
      dout_d     = 8'h00;
      busdir_n_d = 1'b1;
      wait_n_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= ST_IDLE;
      bank_q      <= BANK_REG_INIT;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      is_read_q   <= 1'b0;
      abort_q     <= 1'b0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      dout_q      <= 8'h00;
      busdir_n_q  <= 1'b1;
      wait_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      is_read_q   <= is_read_d;
      abort_q     <= abort_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dout_q      <= dout_d;
      busdir_n_q  <= busdir_n_d;
      wait_n_q    <= wait_n_d;
    end
  end

  // A bus reset releases the Z80 in the same cycle it is asserted.
  assign WAIT_n    = wait_n_q | ~BUS_RESET_n;
  assign DOUT      = dout_q;
  assign BUSDIR_n  = busdir_n_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_megarom_bank_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_megarom_bank_controller
//  Purpose  : Directed and randomized checks of megarom_bank_controller
//             against a page-arithmetic model of the megarom mapper.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_megarom_bank_controller;

  logic              CLK = 1'b0;
  logic              RESET_n, BUS_RESET_n;
  logic              SLTSL_n, MERQ_n, RD_n, WR_n;
  logic [15:0]       ADDR;
  logic [7:0]        DIN;
  logic [7:0]        DOUT;
  logic              BUSDIR_n, WAIT_n;
  logic [3:0][15:0]  BANK_REG_ADDR;
  logic [15:0]       BANK_REG_ADDR_MASK;
  logic [7:0]        BANK_REG_MASK;
  logic [3:0][7:0]   BANK_REG_INIT;
  logic              WRITE_PROTECT, IS_16K_BANK, CS1_MASK, CS2_MASK;
  logic [31:0]       MEM_TOP_ADDR;
  logic              MEM_REQ, MEM_WE;
  logic [31:0]       MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic              MEM_ACK;
  logic [7:0]        MEM_RDATA;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: the four mapper page registers.
  logic [7:0] m_bank [4];

  megarom_bank_controller #(.MEM_AW(32)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n),
    .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .RD_n(RD_n), .WR_n(WR_n),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n),
    .BANK_REG_ADDR(BANK_REG_ADDR), .BANK_REG_ADDR_MASK(BANK_REG_ADDR_MASK),
    .BANK_REG_MASK(BANK_REG_MASK), .BANK_REG_INIT(BANK_REG_INIT),
    .WRITE_PROTECT(WRITE_PROTECT), .IS_16K_BANK(IS_16K_BANK),
    .CS1_MASK(CS1_MASK), .CS2_MASK(CS2_MASK), .MEM_TOP_ADDR(MEM_TOP_ADDR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cartridge window test, at the byte-address level.
  function automatic bit in_win(input logic [15:0] a);
    int ia;
    ia = int'(a);
    return ((ia >= 'h4000) && (ia < 'h8000) && !CS1_MASK) ||
           ((ia >= 'h8000) && (ia < 'hC000) && !CS2_MASK);
  endfunction

  // Which bank registers a write to address a would load.
  function automatic logic [3:0] hits(input logic [15:0] a);
    logic [3:0] h;
    for (int i = 0; i < 4; i++) begin
      h[i] = ((a ^ BANK_REG_ADDR[i]) & ~BANK_REG_ADDR_MASK) == 16'h0;
    end
    return h;
  endfunction

  // Image address = base + page_number * page_size + offset within page.
  function automatic logic [31:0] exp_addr(input logic [15:0] a);
    int          page_sz, idx;
    logic [31:0] off;
    page_sz = IS_16K_BANK ? 16384 : 8192;
    idx     = (int'(a) - 'h4000) / page_sz;
    off     = 32'(m_bank[idx]) * 32'(page_sz) + 32'(int'(a) % page_sz);
    return MEM_TOP_ADDR + off;
  endfunction

  task automatic release_bus();
    RD_n = 1'b1; WR_n = 1'b1; SLTSL_n = 1'b1; MERQ_n = 1'b1;
  endtask

  // One complete bus access, with expectations derived from the model.
  task automatic access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                        input int dly, input logic [7:0] rdat, input bit abort);
    logic [3:0]  h;
    bit          req_exp;
    logic [31:0] ea;
    h       = is_wr ? hits(a) : 4'b0000;
    req_exp = (h == 4'b0000) && in_win(a) && (!is_wr || !WRITE_PROTECT);
    ea      = req_exp ? exp_addr(a) : 32'h0;
    ADDR = a; DIN = d; SLTSL_n = 1'b0; MERQ_n = 1'b0;
    if (is_wr) WR_n = 1'b0; else RD_n = 1'b0;
    @(negedge CLK);
    if (req_exp) begin
      chk("req_start", 64'(MEM_REQ), 64'd1);
      chk("wait_low",  64'(WAIT_n), 64'd0);
      chk("mem_addr",  64'(MEM_ADDR), 64'(ea));
      chk("mem_we",    64'(MEM_WE), 64'(is_wr));
      if (is_wr) chk("mem_wdata", 64'(MEM_WDATA), 64'(d));
      if (abort) RD_n = 1'b1;
      for (int k = 1; k < dly; k++) begin
        @(negedge CLK);
        chk("req_hold", 64'({MEM_REQ, WAIT_n}), 64'(2'b10));
        chk("addr_hold", 64'(MEM_ADDR), 64'(ea));
      end
      MEM_ACK = 1'b1; MEM_RDATA = rdat;
      @(negedge CLK);
      MEM_ACK = 1'b0; MEM_RDATA = 8'($urandom);
      chk("req_done", 64'({MEM_REQ, WAIT_n}), 64'(2'b01));
      if (!is_wr && !abort) begin
        chk("rd_drive", 64'({BUSDIR_n, DOUT}), 64'({1'b0, rdat}));
        @(negedge CLK);
        chk("rd_keep", 64'({BUSDIR_n, DOUT}), 64'({1'b0, rdat}));
      end else begin
        chk("no_drive", 64'({BUSDIR_n, DOUT}), 64'({1'b1, 8'h00}));
      end
    end else begin
      repeat (2) begin
        @(negedge CLK);
        chk("no_req", 64'({MEM_REQ, WAIT_n, BUSDIR_n}), 64'(3'b011));
      end
    end
    release_bus();
    @(negedge CLK);
    chk("released", 64'({BUSDIR_n, DOUT}), 64'({1'b1, 8'h00}));
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      if (h[i]) m_bank[i] = d & BANK_REG_MASK;
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] ea;

    RESET_n = 1'b0; BUS_RESET_n = 1'b1;
    SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    ADDR = 16'h0; DIN = 8'h0; MEM_ACK = 1'b0; MEM_RDATA = 8'h0;
    BANK_REG_INIT      = {8'h04, 8'h03, 8'h02, 8'h01};
    BANK_REG_ADDR      = {16'h7800, 16'h7000, 16'h6000, 16'h5000};
    BANK_REG_ADDR_MASK = 16'h07FF;
    BANK_REG_MASK      = 8'h3F;
    WRITE_PROTECT = 1'b0; IS_16K_BANK = 1'b0; CS1_MASK = 1'b0; CS2_MASK = 1'b0;
    MEM_TOP_ADDR = 32'h0010_0000;
    for (int i = 0; i < 4; i++) m_bank[i] = BANK_REG_INIT[i];

    repeat (3) @(negedge CLK);
    chk("rst_bus", 64'({DOUT, BUSDIR_n, WAIT_n}), 64'({8'h00, 1'b1, 1'b1}));
    chk("rst_mem", 64'({MEM_REQ, MEM_WE, MEM_WDATA}), 64'd0);
    chk("rst_addr", 64'(MEM_ADDR), 64'd0);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Plan examples, with the expected addresses written out literally.
    access(1'b0, 16'h6123, 8'h00, 3, 8'h5A, 1'b0);
    chk("ex1_model", 64'(exp_addr(16'h6123)), 64'h0010_4123);
    access(1'b1, 16'h57FF, 8'hFF, 1, 8'h00, 1'b0);
    chk("ex2_bank0", 64'(m_bank[0]), 64'h3F);
    access(1'b0, 16'h4000, 8'h00, 2, 8'hC3, 1'b0);
    access(1'b1, 16'h6000, 8'h05, 1, 8'h00, 1'b0);
    IS_16K_BANK = 1'b1;
    chk("ex3_model", 64'(exp_addr(16'h8001)), 64'h0011_4001);
    access(1'b0, 16'h8001, 8'h00, 1, 8'h99, 1'b0);
    IS_16K_BANK = 1'b0;
    WRITE_PROTECT = 1'b1;
    access(1'b1, 16'h4000, 8'hA5, 1, 8'h00, 1'b0);
    WRITE_PROTECT = 1'b0;
    access(1'b1, 16'h4000, 8'hA5, 2, 8'h00, 1'b0);
    CS2_MASK = 1'b1;
    access(1'b0, 16'h9000, 8'h00, 1, 8'h11, 1'b0);
    CS2_MASK = 1'b0;
    access(1'b0, 16'h0000, 8'h00, 1, 8'h22, 1'b0);
    access(1'b0, 16'hC000, 8'h00, 1, 8'h23, 1'b0);
    // Bus aborts the read while memory is still busy.
    access(1'b0, 16'hA000, 8'h00, 2, 8'h66, 1'b1);
    access(1'b0, 16'hBFFF, 8'h00, 1, 8'h67, 1'b0);

    // Bus reset while a request is outstanding.
    ea = exp_addr(16'h6123);
    ADDR = 16'h6123; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
    @(negedge CLK);
    chk("br_req", 64'({MEM_REQ, WAIT_n}), 64'(2'b10));
    BUS_RESET_n = 1'b0;
    #1;
    chk("br_wait_now", 64'(WAIT_n), 64'd1);
    repeat (2) begin
      @(negedge CLK);
      chk("br_req_held", 64'({MEM_REQ, WAIT_n, BUSDIR_n}), 64'(3'b111));
      chk("br_addr_held", 64'(MEM_ADDR), 64'(ea));
    end
    MEM_ACK = 1'b1; MEM_RDATA = 8'h77;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk("br_done", 64'({MEM_REQ, BUSDIR_n, DOUT}), 64'({1'b0, 1'b1, 8'h00}));
    release_bus();
    @(negedge CLK);
    BUS_RESET_n = 1'b1;
    for (int i = 0; i < 4; i++) m_bank[i] = BANK_REG_INIT[i];
    @(negedge CLK);
    chk("br_idle", 64'({MEM_REQ, WAIT_n, BUSDIR_n, DOUT}), 64'({3'b011, 8'h00}));
    access(1'b0, 16'h6123, 8'h00, 1, 8'h3C, 1'b0);
    access(1'b0, 16'h4000, 8'h00, 1, 8'h3D, 1'b0);

    // Randomized phase; bank 3 aliases bank 2 so some writes load both.
    MEM_TOP_ADDR       = $urandom;
    BANK_REG_ADDR[0]   = 16'($urandom);
    BANK_REG_ADDR[1]   = 16'($urandom_range(16'h4000, 16'hBFFF));
    BANK_REG_ADDR[2]   = 16'($urandom_range(16'h4000, 16'hBFFF));
    BANK_REG_ADDR[3]   = BANK_REG_ADDR[2];
    BANK_REG_ADDR_MASK = 16'($urandom) & 16'h0FFF;
    BANK_REG_MASK      = 8'($urandom) | 8'h81;
    for (int n = 0; n < 120; n++) begin
      IS_16K_BANK   = 1'($urandom_range(0, 1));
      WRITE_PROTECT = ($urandom_range(0, 3) == 0);
      CS1_MASK      = ($urandom_range(0, 5) == 0);
      CS2_MASK      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else a = BANK_REG_ADDR[$urandom_range(0, 3)] ^ (16'($urandom) & BANK_REG_ADDR_MASK);
      access(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(1, 4),
             8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/megarom_bank_controller.md
Name: megarom_bank_controller

Overview:
Device-side megarom engine that consumes the configuration published by the megarom configuration block (bank register addresses, masks, init values, flags, memory top address).
- Snoops slot writes to maintain four bank registers.
- Translates cartridge reads/writes in 4000h–BFFFh into memory requests over a req/ack handshake.
- Stretches the Z80 cycle with WAIT_n until memory completes.

Parameters:
MEM_AW, 32, width of MEM_ADDR and MEM_TOP_ADDR.

Ports:
CLK  in  1  system clock
RESET_n  in  1  asynchronous, active-low system reset
BUS_RESET_n  in  1  MSX bus reset, synchronous to CLK, active-low
SLTSL_n, MERQ_n, RD_n, WR_n  in  1 each  MSX bus strobes (CLK-synchronised)
ADDR  in  16  bus address
DIN  in  8  bus write data
DOUT  out  8  bus read data
BUSDIR_n  out  1  low while driving DOUT
WAIT_n  out  1  bus wait
BANK_REG_ADDR  in  4x16  bank register match address, bank 0..3
BANK_REG_ADDR_MASK  in  16  1 = address bit ignored in match
BANK_REG_MASK  in  8  1 = bank data bit kept
BANK_REG_INIT  in  4x8  bank reset values
WRITE_PROTECT, IS_16K_BANK, CS1_MASK, CS2_MASK  in  1 each  mode flags
MEM_TOP_ADDR  in  MEM_AW  memory base of image
MEM_REQ  out  1  memory request
MEM_WE  out  1  1 = write
MEM_ADDR  out  MEM_AW  memory byte address
MEM_WDATA  out  8  write data
MEM_ACK  in  1  one-cycle completion pulse
MEM_RDATA  in  8  read data, valid with MEM_ACK

Behaviour:
- rd_n = SLTSL_n|MERQ_n|RD_n; wr_n likewise with WR_n. Falling edges are detected against a registered copy; the registered copy resets to 1.
- Reset (RESET_n low, async):
  - bank[i]=BANK_REG_INIT[i].
  - DOUT=0, BUSDIR_n=1, WAIT_n=1.
  - MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
  - State IDLE.
- BUS_RESET_n low:
  - bank[i] reloads INIT.
  - No new requests accepted.
  - WAIT_n=1, BUSDIR_n=1, DOUT=0.
  - An outstanding MEM_REQ stays high until MEM_ACK; the result is discarded, then IDLE.
- Windows:
  - cs1 = ADDR[15:14]==01 & !CS1_MASK.
  - cs2 = ADDR[15:14]==10 & !CS2_MASK.
  - Accesses outside both windows are ignored entirely (BUSDIR_n stays 1).
- Bank select:
  - 8K mode: bank = ADDR[14:13]-2 mod 4 (4000h→0, 6000h→1, 8000h→2, A000h→3).
  - 16K mode: 4000h–7FFFh→bank0, 8000h–BFFFh→bank1.
- Address translation:
  - 8K mode: MEM_ADDR = MEM_TOP_ADDR + {bank, ADDR[12:0]}.
  - 16K mode: MEM_ADDR = MEM_TOP_ADDR + {bank, ADDR[13:0]}.
  - Addition is modulo 2^MEM_AW.
- Bank write:
  - Trigger: wr_n falling edge with SLTSL active, for each i where (ADDR ^ BANK_REG_ADDR[i]) & ~BANK_REG_ADDR_MASK == 0.
  - Action: bank[i] <= DIN & BANK_REG_MASK.
  - Multiple matches all update in the same cycle.
  - A bank write never produces a memory write, and requires no window.
  - A bank update never changes a request already in flight.
- FSM IDLE/REQ/HOLD:
  - IDLE → REQ on a qualifying edge. The edge is detected in cycle N; at N+1: MEM_REQ=1, WAIT_n=0, MEM_ADDR/MEM_WE/MEM_WDATA registered and held stable through REQ.
  - Qualifying edge: rd_n fall in a window; or wr_n fall in a window with WRITE_PROTECT=0 and no bank match.
  - A write with WRITE_PROTECT=1 is dropped silently.
  - REQ → HOLD on MEM_ACK: next cycle MEM_REQ=0, WAIT_n=1. For reads, DOUT=MEM_RDATA and BUSDIR_n=0.
  - HOLD → IDLE when the originating strobe (rd_n/wr_n) returns high: BUSDIR_n=1, DOUT=0.
  - If rd_n rises while in REQ (bus aborted), the request still completes, no data is driven, then IDLE.
- Edges arriving outside IDLE are ignored.
- The flags and masks are treated as quasi-static; no changes mid-access.

Test Plan:
- Reset, INIT={01,02,03,04}, 8K mode, CS masks 0, MEM_TOP=0010_0000h; read 6123h, ack after 3 cycles with 5Ah → MEM_ADDR=0010_4123h, WAIT_n low 3+1 cycles, DOUT=5Ah with BUSDIR_n=0 until RD_n high.
- BANK_REG_ADDR0=5000h, ADDR_MASK=07FFh, BANK_REG_MASK=3Fh; write FFh to 57FFh → bank0=3Fh, no MEM_REQ; next read 4000h → MEM_ADDR=MEM_TOP+7E000h.
- 16K mode, bank1=05h; read 8001h → MEM_ADDR=MEM_TOP+14001h.
- WRITE_PROTECT=1, write A5h to 4000h → no MEM_REQ, WAIT_n stays 1; WRITE_PROTECT=0 repeat → MEM_WE=1, MEM_WDATA=A5h.
- CS2_MASK=1, read 9000h → no request, BUSDIR_n=1; read 0000h → ignored.
- BUS_RESET_n pulsed while in REQ → banks back to INIT, WAIT_n=1 immediately, MEM_REQ held until ack then 0, DOUT stays 0.
